// File: rtl/btb_assoc_if.sv
// rtl/btb_assoc_if.sv - fetch lookup and branch-resolution update bundle for btb_assoc
interface btb_assoc_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] fetch_pc;
    logic             hit;
    logic             predict_taken;
    logic [WIDTH-1:0] predicted_pc;
    logic             update_valid;
    logic [WIDTH-1:0] update_pc;
    logic [WIDTH-1:0] update_target;
    logic             update_taken;
    logic             flush;

    modport master (
        output fetch_pc, update_valid, update_pc, update_target, update_taken, flush,
        input  hit, predict_taken, predicted_pc
    );

    modport slave (
        input  fetch_pc, update_valid, update_pc, update_target, update_taken, flush,
        output hit, predict_taken, predicted_pc
    );
endinterface

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - 2-way set-associative BTB with saturating direction counters and per-set LRU
module btb_assoc #(
    parameter int WIDTH     = 16,
    parameter int SETS_LOG2 = 3,
    parameter int CTR_BITS  = 2
) (
    input  logic        clk,
    input  logic        reset,
    btb_assoc_if.slave  bus
);
    localparam int SETS = 1 << SETS_LOG2;
    localparam int TW   = WIDTH - SETS_LOG2 - 1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_ONE << (CTR_BITS - 1);

    logic                r_valid  [2][SETS];
    logic [TW-1:0]       r_tag    [2][SETS];
    logic [WIDTH-1:0]    r_target [2][SETS];
    logic [CTR_BITS-1:0] r_ctr    [2][SETS];
    logic                r_lru    [SETS];

    logic [SETS_LOG2-1:0] w_f_idx, w_u_idx;
    logic [TW-1:0]        w_f_tag, w_u_tag;
    logic [1:0]           w_f_hit, w_u_hit;
    logic                 w_u_any_hit;
    logic                 w_u_way;
    logic                 w_unused;

    assign w_f_idx  = bus.fetch_pc[SETS_LOG2:1];
    assign w_f_tag  = bus.fetch_pc[WIDTH-1:SETS_LOG2+1];
    assign w_u_idx  = bus.update_pc[SETS_LOG2:1];
    assign w_u_tag  = bus.update_pc[WIDTH-1:SETS_LOG2+1];
    assign w_unused = bus.fetch_pc[0] ^ bus.update_pc[0];

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                     input logic tk);
        if (tk)
            return (c == CTR_MAX) ? c : c + CTR_ONE;
        else
            return (c == '0) ? c : c - CTR_ONE;
    endfunction

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            w_f_hit[w] = r_valid[w][w_f_idx] && (r_tag[w][w_f_idx] == w_f_tag);
            w_u_hit[w] = r_valid[w][w_u_idx] && (r_tag[w][w_u_idx] == w_u_tag);
        end
    end

    always_comb begin
        bus.hit           = |w_f_hit;
        bus.predict_taken = 1'b0;
        bus.predicted_pc  = '0;
        if (w_f_hit[0]) begin
            bus.predict_taken = r_ctr[0][w_f_idx][CTR_BITS-1];
            bus.predicted_pc  = r_target[0][w_f_idx];
        end else if (w_f_hit[1]) begin
            bus.predict_taken = r_ctr[1][w_f_idx][CTR_BITS-1];
            bus.predicted_pc  = r_target[1][w_f_idx];
        end
    end

    // Hit way if present, otherwise the allocation victim: first invalid way, else LRU.
    always_comb begin
        w_u_any_hit = |w_u_hit;
        if (w_u_hit[0])
            w_u_way = 1'b0;
        else if (w_u_hit[1])
            w_u_way = 1'b1;
        else if (!r_valid[0][w_u_idx])
            w_u_way = 1'b0;
        else if (!r_valid[1][w_u_idx])
            w_u_way = 1'b1;
        else
            w_u_way = r_lru[w_u_idx];
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[0][s] <= 1'b0;
                r_valid[1][s] <= 1'b0;
                r_lru[s]      <= 1'b0;
            end
        end else if (bus.update_valid) begin
            if (w_u_any_hit) begin
                r_target[w_u_way][w_u_idx] <= bus.update_target;
                r_ctr[w_u_way][w_u_idx]    <= ctr_next(r_ctr[w_u_way][w_u_idx], bus.update_taken);
                r_lru[w_u_idx]             <= ~w_u_way;
            end else if (bus.update_taken) begin
                r_valid[w_u_way][w_u_idx]  <= 1'b1;
                r_tag[w_u_way][w_u_idx]    <= w_u_tag;
                r_target[w_u_way][w_u_idx] <= bus.update_target;
                r_ctr[w_u_way][w_u_idx]    <= CTR_INIT;
                r_lru[w_u_idx]             <= ~w_u_way;
            end
        end
    end

    // A tag is never allocated twice in one set, so two matching ways means corrupted state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_f_hit[0] && w_f_hit[1]));
            assert (!(w_u_hit[0] && w_u_hit[1]));
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed self-checking bench for btb_assoc
module tb_btb_assoc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    btb_assoc_if #(.WIDTH(16)) bus ();

    btb_assoc #(.WIDTH(16), .SETS_LOG2(3), .CTR_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic ehit,
                        input logic ept, input logic [15:0] epc);
        bus.fetch_pc = pc;
        #1;
        chk({tag, ".hit"}, 32'(bus.hit), 32'(ehit));
        chk({tag, ".taken"}, 32'(bus.predict_taken), 32'(ept));
        chk({tag, ".pc"}, 32'(bus.predicted_pc), 32'(epc));
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        bus.update_valid  = 1'b1;
        bus.update_pc     = pc;
        bus.update_target = tgt;
        bus.update_taken  = tk;
        tick();
        bus.update_valid  = 1'b0;
    endtask

    initial begin
        bus.fetch_pc      = '0;
        bus.update_valid  = 1'b0;
        bus.update_pc     = '0;
        bus.update_target = '0;
        bus.update_taken  = 1'b0;
        bus.flush         = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        look("reset", 16'h1004, 1'b0, 1'b0, 16'h0000);

        // same-cycle lookup sees pre-update contents
        bus.update_valid  = 1'b1;
        bus.update_pc     = 16'h1004;
        bus.update_target = 16'h2000;
        bus.update_taken  = 1'b1;
        look("bypass", 16'h1004, 1'b0, 1'b0, 16'h0000);
        tick();
        bus.update_valid = 1'b0;
        look("alloc", 16'h1004, 1'b1, 1'b1, 16'h2000);

        upd(16'h1004, 16'h2000, 1'b0);
        look("ctr1", 16'h1004, 1'b1, 1'b0, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b0);
        look("ctr0", 16'h1004, 1'b1, 1'b0, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b0);
        look("ctr0_hold", 16'h1004, 1'b1, 1'b0, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b1);
        look("ctr1_up", 16'h1004, 1'b1, 1'b0, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b1);
        look("ctr2_up", 16'h1004, 1'b1, 1'b1, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b1);
        upd(16'h1004, 16'h2000, 1'b1);
        upd(16'h1004, 16'h2000, 1'b1);
        look("ctr3_sat", 16'h1004, 1'b1, 1'b1, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b0);
        look("ctr3_to2", 16'h1004, 1'b1, 1'b1, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b0);
        look("ctr2_to1", 16'h1004, 1'b1, 1'b0, 16'h2000);

        // set 2: 0x1004 in way0, 0x2004 fills way1, refresh 0x1004 so 0x2004 is LRU
        upd(16'h2004, 16'h2100, 1'b1);
        look("way1_fill", 16'h2004, 1'b1, 1'b1, 16'h2100);
        look("way0_keep", 16'h1004, 1'b1, 1'b0, 16'h2000);
        upd(16'h1004, 16'h2000, 1'b1);
        upd(16'h3004, 16'h4000, 1'b1);
        look("lru_evict", 16'h2004, 1'b0, 1'b0, 16'h0000);
        look("lru_keep", 16'h1004, 1'b1, 1'b1, 16'h2000);
        look("lru_new", 16'h3004, 1'b1, 1'b1, 16'h4000);

        upd(16'h5000, 16'h5100, 1'b0);
        look("nt_miss", 16'h5000, 1'b0, 1'b0, 16'h0000);

        bus.flush = 1'b1;
        upd(16'h6000, 16'h6100, 1'b1);
        bus.flush = 1'b0;
        look("flush_a", 16'h1004, 1'b0, 1'b0, 16'h0000);
        look("flush_b", 16'h6000, 1'b0, 1'b0, 16'h0000);
        look("flush_c", 16'h3004, 1'b0, 1'b0, 16'h0000);

        upd(16'h1004, 16'h2200, 1'b1);
        look("refill", 16'h1004, 1'b1, 1'b1, 16'h2200);
        reset = 1'b1;
        upd(16'h6000, 16'h6100, 1'b1);
        reset = 1'b0;
        look("reset_a", 16'h1004, 1'b0, 1'b0, 16'h0000);
        look("reset_b", 16'h6000, 1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
